alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ALU_LAT, default 1: cycles the shared ALU needs after operands are stable; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_sel  input  4  ALU selection code for requester 0.
REQ-007 req0_a, req0_b  input  64 each  operands for requester 0.
REQ-008 req1_valid, req1_ready, req1_sel, req1_a, req1_b: same directions, widths and meanings for requester 1.
REQ-009 alu_sel  output  4  selection code driven to the shared ALU.
REQ-010 alu_in1, alu_in2  output  64 each  operands driven to the shared ALU.
REQ-011 alu_result  input  64  result returned by the shared ALU.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts response when high with rsp_valid.
REQ-014 rsp_id  output  1  index of the requester that issued the response.
REQ-015 rsp_data  output  64  captured ALU result.

Function
REQ-016 State machine SHALL have states IDLE, EXEC, RESP; internal round-robin pointer rr (1 bit) names the preferred requester.
REQ-017 In IDLE, with both valids high, grant SHALL go to requester rr; with one valid high, grant SHALL go to that requester regardless of rr.
REQ-018 reqN_ready SHALL be high only in IDLE, only for the granted requester, and SHALL be combinational from valids and rr; it SHALL be low in EXEC and RESP.
REQ-019 On acceptance (valid && ready), sel/a/b SHALL be registered into alu_sel/alu_in1/alu_in2, the granted index stored, a 4-bit counter loaded with ALU_LAT, and state -> EXEC.
REQ-020 alu_sel/alu_in1/alu_in2 SHALL remain stable from the cycle after acceptance until the next acceptance.
REQ-021 EXEC SHALL last exactly ALU_LAT cycles (counter decrements each cycle); in the final EXEC cycle alu_result SHALL be captured into rsp_data and state -> RESP.
REQ-022 Latency: acceptance at cycle T SHALL give rsp_valid high first in cycle T+ALU_LAT+1.
REQ-023 In RESP, rsp_valid SHALL be high and rsp_data/rsp_id held constant until rsp_ready is sampled high; on that edge state -> IDLE, rsp_valid low next cycle.
REQ-024 On response handshake, rr SHALL be set to the inverse of the served index (served requester gets lowest priority next).
REQ-025 No acceptance SHALL occur in the cycle of the response handshake; earliest next acceptance is the following cycle (max throughput one op per ALU_LAT+2 cycles).
REQ-026 The block SHALL NOT modify or interpret data: rsp_data equals alu_result bit-for-bit; any selection code is forwarded.
REQ-027 A requester deasserting valid before being accepted SHALL cause no acceptance and no state change.

Reset
REQ-028 While rst_n is low at a clock edge: state -> IDLE, rr -> 0, counter -> 0, rsp_valid/rsp_id/rsp_data/alu_sel/alu_in1/alu_in2 -> 0; reqN_ready low while rst_n low.
REQ-029 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response for it SHALL appear after reset release.

Verification
REQ-030 ALU_LAT=1, req0 sel=0010 a=5 b=7 accepted cycle 0, ALU adds -> rsp_valid cycle 2, rsp_data=12, rsp_id=0.
REQ-031 After reset both valids high continuously, rsp_ready=1 -> grant order req0, req1, req0, req1; reqN_ready never high in EXEC/RESP.
REQ-032 Only req1 valid repeatedly -> req1 served every time, acceptances spaced ALU_LAT+2 cycles.
REQ-033 rsp_ready low 3 cycles in RESP -> rsp_valid, rsp_data, rsp_id unchanged those cycles; IDLE one cycle after handshake.
REQ-034 ALU_LAT=4, sel=0011 a=0 b=1 -> rsp_valid at T+5, rsp_data=0xFFFF_FFFF_FFFF_FFFF; operand outputs stable T+1..T+5.
REQ-035 rst_n low one cycle during EXEC -> all outputs 0 next cycle, no rsp_valid afterwards until a new acceptance.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one multi-cycle ALU between two
// requesters. One operation is in flight at a time: accept, wait ALU_LAT cycles,
// hold the captured result until the consumer takes it, then return to idle.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_sel,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_sel,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  output logic [3:0]  alu_sel,
  output logic [63:0] alu_in1,
  output logic [63:0] alu_in2,
  input  logic [63:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_data
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      r_state;
  logic        r_rr;
  logic [3:0]  r_cnt;
  logic        r_id;
  logic [3:0]  r_alu_sel;
  logic [63:0] r_alu_in1;
  logic [63:0] r_alu_in2;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [63:0] r_rsp_data;

  logic        w_idle;
  logic        w_gnt0;
  logic        w_gnt1;

  // Grant is purely combinational so a requester sees ready in the same cycle
  // it raises valid; a lone requester wins regardless of the rr pointer.
  assign w_idle = rst_n && (r_state == IDLE);
  assign w_gnt0 = w_idle && req0_valid && (!req1_valid || !r_rr);
  assign w_gnt1 = w_idle && req1_valid && (!req0_valid ||  r_rr);

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign alu_sel    = r_alu_sel;
  assign alu_in1    = r_alu_in1;
  assign alu_in2    = r_alu_in2;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;

  // Control FSM: accept in IDLE, count down the ALU latency in EXEC, hold the
  // response in RESP until the consumer handshakes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr        <= 1'b0;
      r_cnt       <= 4'd0;
      r_id        <= 1'b0;
      r_alu_sel   <= 4'd0;
      r_alu_in1   <= 64'd0;
      r_alu_in2   <= 64'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= 64'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_alu_sel <= w_gnt1 ? req1_sel : req0_sel;
            r_alu_in1 <= w_gnt1 ? req1_a   : req0_a;
            r_alu_in2 <= w_gnt1 ? req1_b   : req0_b;
            r_id      <= w_gnt1;
            r_cnt     <= 4'(ALU_LAT);
            r_state   <= EXEC;
          end
        end
        EXEC: begin
          // Count of 1 marks the last cycle the ALU needs; sample its result now.
          if (r_cnt <= 4'd1) begin
            r_cnt       <= 4'd0;
            r_rsp_data  <= alu_result;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          // Served requester drops to lowest priority for the next arbitration.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr        <= ~r_rsp_id;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LAT=1 and one with
// ALU_LAT=4, each fed by a behavioural ALU model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A (ALU_LAT=1)
  logic        a0v, a0r, a1v, a1r;
  logic [3:0]  a0s, a1s, a_sel;
  logic [63:0] a0a, a0b, a1a, a1b, a_in1, a_in2, a_res, a_data;
  logic        a_rv, a_rr, a_id;

  // Instance B (ALU_LAT=4)
  logic        b0v, b0r, b1v, b1r;
  logic [3:0]  b0s, b1s, b_sel;
  logic [63:0] b0a, b0b, b1a, b1b, b_in1, b_in2, b_res, b_data;
  logic        b_rv, b_rr, b_id;

  function automatic logic [63:0] alu_f(input logic [3:0] s, input logic [63:0] x,
                                        input logic [63:0] y);
    case (s)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return x + y;
      4'd3:    return x - y;
      default: return x ^ y;
    endcase
  endfunction

  assign a_res = alu_f(a_sel, a_in1, a_in2);
  assign b_res = alu_f(b_sel, b_in1, b_in2);

  alu_arbiter #(.ALU_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a0v), .req0_ready(a0r), .req0_sel(a0s), .req0_a(a0a), .req0_b(a0b),
    .req1_valid(a1v), .req1_ready(a1r), .req1_sel(a1s), .req1_a(a1a), .req1_b(a1b),
    .alu_sel(a_sel), .alu_in1(a_in1), .alu_in2(a_in2), .alu_result(a_res),
    .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_id(a_id), .rsp_data(a_data)
  );

  alu_arbiter #(.ALU_LAT(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b0v), .req0_ready(b0r), .req0_sel(b0s), .req0_a(b0a), .req0_b(b0b),
    .req1_valid(b1v), .req1_ready(b1r), .req1_sel(b1s), .req1_a(b1a), .req1_b(b1b),
    .alu_sel(b_sel), .alu_in1(b_in1), .alu_in2(b_in2), .alu_result(b_res),
    .rsp_valid(b_rv), .rsp_ready(b_rr), .rsp_id(b_id), .rsp_data(b_data)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a0v = 0; a0s = 0; a0a = 0; a0b = 0; a1v = 0; a1s = 0; a1a = 0; a1b = 0; a_rr = 0;
    b0v = 0; b0s = 0; b0a = 0; b0b = 0; b1v = 0; b1s = 0; b1a = 0; b1b = 0; b_rr = 0;

    // Reset state, ready held low while in reset even with valid high
    cyc(); cyc();
    a0v = 1; #1;
    check("rst_rdy0", a0r, 0);
    check("rst_rsp_valid", a_rv, 0);
    check("rst_rsp_data", a_data, 0);
    check("rst_alu_in1", a_in1, 0);
    check("rst_alu_sel", a_sel, 0);
    a0v = 0;
    rst_n = 1'b1;
    cyc();

    // Basic add: req0 sel=2 a=5 b=7 accepted cycle 0
    a0v = 1; a0s = 4'd2; a0a = 64'd5; a0b = 64'd7; #1;
    check("add_rdy0", a0r, 1);
    check("add_rdy1", a1r, 0);
    cyc();
    a0v = 0; a0a = 64'd100;
    check("add_exec_sel", a_sel, 4'd2);
    check("add_exec_in1", a_in1, 64'd5);
    check("add_exec_in2", a_in2, 64'd7);
    check("add_exec_rv", a_rv, 0);
    cyc();
    check("add_rsp_valid", a_rv, 1);
    check("add_rsp_data", a_data, 64'd12);
    check("add_rsp_id", a_id, 0);

    // Back-pressure: rsp_ready low three cycles, response held; ready low in RESP
    a1v = 1; #1;
    check("resp_rdy1", a1r, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("hold_rv", a_rv, 1);
      check("hold_data", a_data, 64'd12);
      check("hold_id", a_id, 0);
    end
    a1v = 0;
    a_rr = 1;
    cyc();
    a_rr = 0;
    check("hs_rv_low", a_rv, 0);

    // Served req0 now lowest priority
    a0v = 1; a1v = 1; #1;
    check("rr_after_hs_rdy1", a1r, 1);
    check("rr_after_hs_rdy0", a0r, 0);
    a0v = 0; a1v = 0; #1;
    check("drop_valid_rdy1", a1r, 0);
    cyc();
    check("drop_valid_no_exec", a_sel, 4'd2);
    a0v = 1; #1;
    check("still_idle_rdy0", a0r, 1);
    a0v = 0;

    // Round robin from fresh reset, both valid, consumer always ready
    rst_n = 0; cyc(); rst_n = 1;
    a0v = 1; a0s = 4'd0; a0a = 64'hF0; a0b = 64'h3C;
    a1v = 1; a1s = 4'd1; a1a = 64'hF0; a1b = 64'h0F;
    a_rr = 1; #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_rdy0", a0r, (i % 2) == 0);
      check("rr_rdy1", a1r, (i % 2) == 1);
      cyc();
      check("rr_exec_rdy", {a0r, a1r}, 0);
      cyc();
      check("rr_rsp_rdy", {a0r, a1r}, 0);
      check("rr_rv", a_rv, 1);
      check("rr_id", a_id, i % 2);
      check("rr_data", a_data, ((i % 2) == 0) ? 64'h30 : 64'hFF);
      cyc();
    end

    // Only req1 requesting: served every time, one acceptance per 3 cycles
    a0v = 0; a1s = 4'd3; a1a = 64'd10; a1b = 64'd3; #1;
    for (int i = 0; i < 2; i++) begin
      check("solo_rdy1", a1r, 1);
      check("solo_rdy0", a0r, 0);
      cyc();
      check("solo_exec_rdy1", a1r, 0);
      check("solo_exec_sel", a_sel, 4'd3);
      cyc();
      check("solo_rv", a_rv, 1);
      check("solo_id", a_id, 1);
      check("solo_data", a_data, 64'd7);
      cyc();
    end
    a1v = 0; a_rr = 0;

    // Reset during EXEC on the LAT=1 instance
    a0v = 1; a0s = 4'd2; a0a = 64'd1; a0b = 64'd1; #1;
    cyc();
    a0v = 0;
    check("rexec_in1", a_in1, 64'd1);
    rst_n = 0;
    cyc();
    a0v = 1; #1;
    check("rexec_rdy0", a0r, 0);
    check("rexec_sel", a_sel, 0);
    check("rexec_in1z", a_in1, 0);
    check("rexec_in2z", a_in2, 0);
    check("rexec_rv", a_rv, 0);
    check("rexec_data", a_data, 0);
    check("rexec_id", a_id, 0);
    a0v = 0; rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("rexec_no_rsp", a_rv, 0);
    end

    // LAT=4: 0 - 1 response at T+5, operands stable T+1..T+5
    b0v = 1; b0s = 4'd3; b0a = 64'd0; b0b = 64'd1; #1;
    check("l4_rdy0", b0r, 1);
    cyc();
    b0v = 0; b0s = 4'd0; b0a = 64'd99; b0b = 64'd5;
    for (int k = 1; k <= 5; k++) begin
      check("l4_sel", b_sel, 4'd3);
      check("l4_in1", b_in1, 64'd0);
      check("l4_in2", b_in2, 64'd1);
      check("l4_rv", b_rv, k == 5);
      if (k < 5) cyc();
    end
    check("l4_data", b_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("l4_id", b_id, 0);
    b_rr = 1;
    cyc();
    b_rr = 0;
    check("l4_hs_rv", b_rv, 0);

    // Reset one cycle mid-EXEC on the LAT=4 instance discards the operation
    b1v = 1; b1s = 4'd2; b1a = 64'd2; b1b = 64'd3; #1;
    check("l4r_rdy1", b1r, 1);
    cyc();
    b1v = 0;
    cyc();
    rst_n = 0;
    cyc();
    rst_n = 1;
    check("l4r_sel", b_sel, 0);
    check("l4r_in1", b_in1, 0);
    check("l4r_in2", b_in2, 0);
    check("l4r_data", b_data, 0);
    check("l4r_id", b_id, 0);
    for (int k = 0; k < 8; k++) begin
      check("l4r_no_rsp", b_rv, 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
